// File: rtl/sum_pkg.sv
// sum_pkg: shared definitions for the Sum kernel loader.
//   state_t      - loader FSM states (IDLE .. RESULT)
//   DATA_W_DEF   - default element / result width
//   K_W          - width of the kernel's scalar and address ports
package sum_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int K_W        = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        START,
        WAIT,
        RESULT
    } state_t;

    // The loader side drives the RAMs and may accept input beats in these states.
    function automatic logic loader_owns(input state_t s);
        return (s == IDLE) || (s == LOAD) || (s == DRAIN);
    endfunction

    // The kernel's memory ports drive the RAMs only while it is started or running.
    function automatic logic kernel_owns(input state_t s);
        return (s == START) || (s == WAIT);
    endfunction

endpackage

// File: rtl/sum_bram.sv
// sum_bram: single-port RAM, synchronous read with one cycle of latency.
//   clk    - clock
//   ce     - port enable; q updates only when ce is high
//   we     - write enable (qualified by ce)
//   addr   - word address
//   wdata  - write data
//   q      - read data, valid the cycle after ce (returns the old word on a write)
module sum_bram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              ce,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the storage array has no reset so it maps onto block RAM; its contents
    // are simply whatever was last written.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/sum_loader.sv
// sum_loader: upstream feeder for the HLS Sum kernel.
//   Loads a packet of (a,b) pairs into two local RAMs, starts the kernel with the
//   packet length, lends it the RAMs while it runs and returns its result.
// Ports:
//   sys_clk, sys_rst                 - clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b/in_last - input packet stream
//   k_start, k_n                     - kernel start pulse and element count
//   k_done, k_return_val             - kernel completion and result
//   k_a_* / k_b_*                    - kernel memory ports for arrays a and b
//   res_valid/res_ready/res_data/res_trunc - result stream, truncation flag
module sum_loader
    import sum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic              k_start,
    output logic [K_W-1:0]    k_n,
    input  logic              k_done,
    input  logic [K_W-1:0]    k_return_val,
    input  logic [K_W-1:0]    k_a_address0,
    input  logic              k_a_ce0,
    input  logic              k_a_we0,
    input  logic [DATA_W-1:0] k_a_ad0,
    output logic [DATA_W-1:0] k_a_q0,
    input  logic [K_W-1:0]    k_b_address0,
    input  logic              k_b_ce0,
    input  logic              k_b_we0,
    input  logic [DATA_W-1:0] k_b_ad0,
    output logic [DATA_W-1:0] k_b_q0,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_trunc
);

    localparam int DEPTH = 2**ADDR_W;

    state_t            state, state_d;
    logic [ADDR_W-1:0] cnt;
    logic              accept;
    logic              load_we;
    logic              at_top;
    logic              k_sel;

    logic              a_ce, a_we, b_ce, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wd, b_wd;

    // Kernel addresses wrap modulo DEPTH; the upper bits are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{k_a_address0[K_W-1:ADDR_W], k_b_address0[K_W-1:ADDR_W]};

    assign at_top = (cnt == {ADDR_W{1'b1}});

    // NOTE: every signal assigned in this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state;
        in_ready  = loader_owns(state);
        k_start   = (state == START);
        res_valid = (state == RESULT);
        accept    = in_valid && in_ready;
        load_we   = accept && (state != DRAIN);
        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    if (in_last)     state_d = START;
                    else if (at_top) state_d = DRAIN;
                    else             state_d = LOAD;
                end
            end
            DRAIN:   if (accept && in_last) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (k_done) state_d = RESULT;
            RESULT:  if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            k_n       <= '0;
            res_data  <= '0;
            res_trunc <= 1'b0;
        end else begin
            state <= state_d;
            if (load_we) begin
                // A new packet starts in IDLE; the overflow set below wins for DEPTH == 1.
                if (state == IDLE) res_trunc <= 1'b0;
                if (in_last) begin
                    k_n <= K_W'(cnt) + K_W'(1);
                    cnt <= '0;
                end else if (at_top) begin
                    k_n       <= K_W'(DEPTH);
                    res_trunc <= 1'b1;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (state == WAIT && k_done) begin
                res_data <= DATA_W'(k_return_val);
            end
        end
    end

    // RAM port mux: kernel owns both RAMs in START/WAIT, the loader otherwise.
    // load_we is low outside IDLE/LOAD, so RESULT leaves both RAMs idle.
    always_comb begin
        k_sel  = kernel_owns(state);
        a_ce   = k_sel ? k_a_ce0 : load_we;
        a_we   = k_sel ? k_a_we0 : load_we;
        a_addr = k_sel ? k_a_address0[ADDR_W-1:0] : cnt;
        a_wd   = k_sel ? k_a_ad0 : in_a;
        b_ce   = k_sel ? k_b_ce0 : load_we;
        b_we   = k_sel ? k_b_we0 : load_we;
        b_addr = k_sel ? k_b_address0[ADDR_W-1:0] : cnt;
        b_wd   = k_sel ? k_b_ad0 : in_b;
    end

    sum_bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_a (
        .clk   (sys_clk),
        .ce    (a_ce),
        .we    (a_we),
        .addr  (a_addr),
        .wdata (a_wd),
        .q     (k_a_q0)
    );

    sum_bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_b (
        .clk   (sys_clk),
        .ce    (b_ce),
        .we    (b_we),
        .addr  (b_addr),
        .wdata (b_wd),
        .q     (k_b_q0)
    );

endmodule

// File: tb/tb_sum_loader.sv
// tb_sum_loader: self-checking bench for sum_loader (DATA_W=32, ADDR_W=8).
//   The bench plays both the packet source and the kernel. A reference model
//   holds the expected RAM contents as plain arrays; expected k_n, truncation
//   and sums are derived from packet lengths and the data sent.
module tb_sum_loader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              in_valid, in_ready, in_last;
    logic [DATA_W-1:0] in_a, in_b;
    logic              k_start, k_done;
    logic [31:0]       k_n, k_return_val;
    logic [31:0]       k_a_address0, k_b_address0;
    logic              k_a_ce0, k_a_we0, k_b_ce0, k_b_we0;
    logic [DATA_W-1:0] k_a_ad0, k_b_ad0, k_a_q0, k_b_q0;
    logic              res_valid, res_ready, res_trunc;
    logic [DATA_W-1:0] res_data;

    int total = 0;
    int bad   = 0;

    int unsigned mdl_a [DEPTH];
    int unsigned mdl_b [DEPTH];
    int unsigned q_a [$];
    int unsigned q_b [$];

    sum_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_last      (in_last),
        .k_start      (k_start),
        .k_n          (k_n),
        .k_done       (k_done),
        .k_return_val (k_return_val),
        .k_a_address0 (k_a_address0),
        .k_a_ce0      (k_a_ce0),
        .k_a_we0      (k_a_we0),
        .k_a_ad0      (k_a_ad0),
        .k_a_q0       (k_a_q0),
        .k_b_address0 (k_b_address0),
        .k_b_ce0      (k_b_ce0),
        .k_b_we0      (k_b_we0),
        .k_b_ad0      (k_b_ad0),
        .k_b_q0       (k_b_q0),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_trunc    (res_trunc)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    // All driving and sampling happens 1 ns after the rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_a = '0; in_b = '0; in_last = 0;
        k_done = 0; k_return_val = '0; res_ready = 0;
        k_a_address0 = '0; k_a_ce0 = 0; k_a_we0 = 0; k_a_ad0 = '0;
        k_b_address0 = '0; k_b_ce0 = 0; k_b_we0 = 0; k_b_ad0 = '0;
    endtask

    task automatic fill_random(input int len);
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < len; i++) begin
            q_a.push_back($urandom);
            q_b.push_back($urandom);
        end
    endtask

    // Sends the queued pairs; beats at index >= DEPTH are expected to be dropped.
    task automatic send_packet(input bit with_last, input int gap_max);
        int len, waited, gaps;
        len = q_a.size();
        for (int i = 0; i < len; i++) begin
            gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            in_valid = 0;
            repeat (gaps) tick();
            in_valid = 1;
            in_a     = q_a[i];
            in_b     = q_b[i];
            in_last  = with_last && (i == len - 1);
            waited   = 0;
            while (in_ready !== 1'b1 && waited < 200) begin
                tick();
                waited++;
            end
            if (in_ready !== 1'b1) begin
                total++; bad++;
                $display("FAIL in_ready_timeout: beat %0d never accepted, in_ready=%b", i, in_ready);
                in_valid = 0; in_last = 0;
                return;
            end
            if (i < DEPTH) begin
                mdl_a[i] = q_a[i];
                mdl_b[i] = q_b[i];
            end
            tick();
        end
        in_valid = 0;
        in_last  = 0;
    endtask

    // Called right after the last beat was accepted; leaves the DUT in WAIT.
    task automatic expect_start(input int exp_n, input string tag);
        total++;
        if (k_start !== 1'b1) begin
            bad++; $display("FAIL %s start_latency: k_start=%b want 1", tag, k_start);
        end
        total++;
        if (k_n !== 32'(exp_n)) begin
            bad++; $display("FAIL %s k_n: got %0d want %0d", tag, k_n, exp_n);
        end
        tick();
        total++;
        if (k_start !== 1'b0) begin
            bad++; $display("FAIL %s start_pulse: k_start=%b want 0", tag, k_start);
        end
    endtask

    task automatic k_read(input logic [31:0] addr, output logic [31:0] qa, output logic [31:0] qb);
        k_a_ce0 = 1; k_a_we0 = 0; k_a_address0 = addr;
        k_b_ce0 = 1; k_b_we0 = 0; k_b_address0 = addr;
        tick();
        k_a_ce0 = 0; k_b_ce0 = 0;
        qa = k_a_q0;
        qb = k_b_q0;
    endtask

    task automatic k_write(input logic [31:0] addr, input logic [31:0] da, input logic [31:0] db);
        k_a_ce0 = 1; k_a_we0 = 1; k_a_address0 = addr; k_a_ad0 = da;
        k_b_ce0 = 1; k_b_we0 = 1; k_b_address0 = addr; k_b_ad0 = db;
        tick();
        k_a_ce0 = 0; k_a_we0 = 0; k_b_ce0 = 0; k_b_we0 = 0;
    endtask

    // Kernel reads elements 0..n-1 and checks them against the model.
    task automatic kernel_sum(input int n, input string tag, output int unsigned sum);
        logic [31:0] qa, qb;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            k_read(32'(i), qa, qb);
            total++;
            if (qa !== mdl_a[i] || qb !== mdl_b[i]) begin
                bad++;
                $display("FAIL %s ram_read[%0d]: got a=%0h b=%0h want a=%0h b=%0h",
                         tag, i, qa, qb, mdl_a[i], mdl_b[i]);
            end
            sum += mdl_a[i] + mdl_b[i];
        end
    endtask

    task automatic finish_kernel(input int unsigned sum, input int exp_n, input bit exp_trunc,
                                 input int hold, input string tag);
        total++;
        if (k_start !== 1'b0 || k_n !== 32'(exp_n)) begin
            bad++; $display("FAIL %s wait_state: k_start=%b k_n=%0d want 0 and %0d", tag, k_start, k_n, exp_n);
        end
        k_done = 1; k_return_val = sum;
        tick();
        k_done = 0; k_return_val = $urandom;
        total++;
        if (res_valid !== 1'b1 || res_data !== sum) begin
            bad++; $display("FAIL %s result: valid=%b data=%0d want 1 and %0d", tag, res_valid, res_data, sum);
        end
        total++;
        if (res_trunc !== exp_trunc) begin
            bad++; $display("FAIL %s res_trunc: got %b want %b", tag, res_trunc, exp_trunc);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            total++;
            if (res_valid !== 1'b1 || res_data !== sum) begin
                bad++; $display("FAIL %s result_hold[%0d]: valid=%b data=%0d want 1 and %0d",
                                tag, i, res_valid, res_data, sum);
            end
        end
        res_ready = 1;
        tick();
        res_ready = 0;
        total++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL %s after_handshake: res_valid=%b in_ready=%b want 0 and 1", tag, res_valid, in_ready);
        end
    endtask

    task automatic run_packet(input int len, input int gap_max, input int hold, input string tag);
        int n;
        int unsigned sum;
        fill_random(len);
        send_packet(1'b1, gap_max);
        n = (len < DEPTH) ? len : DEPTH;
        expect_start(n, tag);
        kernel_sum(n, tag, sum);
        finish_kernel(sum, n, len > DEPTH, hold, tag);
    endtask

    task automatic test_reset();
        idle_inputs();
        sys_rst = 1;
        repeat (3) tick();
        total++;
        if (in_ready !== 1'b1 || k_start !== 1'b0 || k_n !== 32'd0 || res_valid !== 1'b0 ||
            res_data !== '0 || res_trunc !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: in_ready=%b k_start=%b k_n=%0d res_valid=%b res_data=%0d res_trunc=%b",
                     in_ready, k_start, k_n, res_valid, res_data, res_trunc);
        end
        sys_rst = 0;
        tick();
    endtask

    task automatic test_basic();
        int unsigned sum;
        q_a = '{1, 2, 3};
        q_b = '{10, 20, 30};
        send_packet(1'b1, 0);
        expect_start(3, "basic");
        kernel_sum(3, "basic", sum);
        finish_kernel(66, 3, 1'b0, 0, "basic");
    endtask

    task automatic test_gaps_and_hold();
        run_packet(20, 3, 5, "gaps");
        run_packet(7, 2, 3, "gaps2");
    endtask

    task automatic test_overflow();
        run_packet(DEPTH + 4, 1, 1, "overflow");
    endtask

    task automatic test_reset_midway();
        logic [31:0] qa, qb;
        // Reset while the kernel is running.
        fill_random(5);
        send_packet(1'b1, 0);
        expect_start(5, "rst_wait");
        k_read(32'd1, qa, qb);
        sys_rst = 1;
        #1;
        total++;
        if (res_valid !== 1'b0 || k_start !== 1'b0 || in_ready !== 1'b1 || k_n !== 32'd0) begin
            bad++; $display("FAIL rst_wait: res_valid=%b k_start=%b in_ready=%b k_n=%0d want 0 0 1 0",
                            res_valid, k_start, in_ready, k_n);
        end
        tick();
        sys_rst = 0;
        tick();
        run_packet(4, 0, 0, "rst_wait_next");
        // Reset part-way through loading a packet.
        fill_random(3);
        send_packet(1'b0, 0);
        total++;
        if (in_ready !== 1'b1 || k_start !== 1'b0) begin
            bad++; $display("FAIL rst_load_pre: in_ready=%b k_start=%b want 1 0", in_ready, k_start);
        end
        sys_rst = 1;
        #1;
        total++;
        if (k_n !== 32'd0 || res_valid !== 1'b0 || k_start !== 1'b0) begin
            bad++; $display("FAIL rst_load: k_n=%0d res_valid=%b k_start=%b want 0 0 0", k_n, res_valid, k_start);
        end
        tick();
        sys_rst = 0;
        tick();
        run_packet(6, 1, 0, "rst_load_next");
    endtask

    task automatic test_kernel_ports();
        logic [31:0] qa, qb, da, db;
        int unsigned sum;
        run_packet(4, 0, 0, "kport_prep");
        // Kernel writes in IDLE must be ignored.
        for (int i = 0; i < 4; i++) k_write(32'(i), $urandom, $urandom);
        fill_random(1);
        send_packet(1'b1, 0);
        expect_start(1, "kport");
        for (int i = 0; i < 4; i++) begin
            k_read(32'(i), qa, qb);
            total++;
            if (qa !== mdl_a[i] || qb !== mdl_b[i]) begin
                bad++; $display("FAIL kport_idle_write[%0d]: got a=%0h b=%0h want a=%0h b=%0h",
                                i, qa, qb, mdl_a[i], mdl_b[i]);
            end
        end
        // Kernel write beyond DEPTH wraps onto the low address bits.
        da = $urandom; db = $urandom;
        k_write(32'h105, da, db);
        mdl_a[5] = da; mdl_b[5] = db;
        k_read(32'h005, qa, qb);
        total++;
        if (qa !== da || qb !== db) begin
            bad++; $display("FAIL kport_wrap_write: got a=%0h b=%0h want a=%0h b=%0h", qa, qb, da, db);
        end
        k_read(32'h305, qa, qb);
        total++;
        if (qa !== da || qb !== db) begin
            bad++; $display("FAIL kport_wrap_read: got a=%0h b=%0h want a=%0h b=%0h", qa, qb, da, db);
        end
        sum = mdl_a[0] + mdl_b[0];
        finish_kernel(sum, 1, 1'b0, 2, "kport");
    endtask

    task automatic test_back_to_back();
        run_packet(1, 0, 0, "b2b_len1");
        run_packet(DEPTH, 0, 0, "b2b_len256");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps_and_hold();
        test_overflow();
        test_back_to_back();
        test_reset_midway();
        test_kernel_ports();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
